// File: rtl/seq_mult_8x8.sv
// seq_mult_8x8: sequential shift-and-add unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Drives a 16-bit ripple adder every cycle and registers its sum into the accumulator.
// Optional build macro: SEQ_MULT_EARLY_EXIT_EN ends the RUN phase once the remaining
// multiplier bits are all zero. The result is the same; only the latency is shorter.

// 16-bit ripple-carry adder that the multiplier datapath feeds.
module _16bit_adder_structural (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  // Carry ripples from bit 0 upward, one full-adder stage per bit.
  always_comb begin
    logic carry;
    carry = cin;
    sum   = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

module seq_mult_8x8 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q,   state_d;
  logic [15:0]        mcand_q,   mcand_d;
  logic [15:0]        acc_q,     acc_d;
  logic [WIDTH-1:0]   mplr_q,    mplr_d;
  logic [2:0]         cnt_q,     cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [15:0]        add_b;
  logic [15:0]        add_sum;
  logic               adder_cout_unused;
  logic [WIDTH-1:0]   mplr_shift;
  logic               last_step;

  // Add the shifted multiplicand only when the current multiplier bit is set.
  assign add_b = mplr_q[0] ? mcand_q : '0;

  _16bit_adder_structural u_adder (
    .a    (acc_q),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (adder_cout_unused)
  );

  assign product = product_q;

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    acc_d      = acc_q;
    mplr_d     = mplr_q;
    cnt_d      = cnt_q;
    product_d  = product_q;
    busy       = 1'b0;
    done       = 1'b0;
    mplr_shift = mplr_q >> 1;
    last_step  = (cnt_q == 3'(WIDTH - 1));
`ifdef SEQ_MULT_EARLY_EXIT_EN
    // No set bits left after this step means every later addend would be zero.
    if (mplr_shift == '0) begin
      last_step = 1'b1;
    end
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = 16'(a);
          mplr_d  = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        acc_d   = add_sum;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_shift;
        cnt_d   = cnt_q + 3'd1;
        if (last_step) begin
          product_d = add_sum[2*WIDTH-1:0];
          state_d   = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      mplr_q    <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mplr_q    <= mplr_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

endmodule

// File: tb/tb_seq_mult_8x8.sv
// Directed bench for seq_mult_8x8 with a scoreboard: stimulus pushes the expected
// product and completion cycle, a negedge monitor pops and compares on each done.
module tb_seq_mult_8x8;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  typedef struct {
    logic [15:0] prod;
    int unsigned done_cyc;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc;
  int          checks;
  int          errors;

  seq_mult_8x8 #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned steps_for(input logic [7:0] bv);
`ifdef SEQ_MULT_EARLY_EXIT_EN
    for (int i = 7; i >= 0; i--) begin
      if (bv[i]) return i + 1;
    end
    return 1;
`else
    return 8;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("product", 32'(product), 32'(e.prod));
        check("done_cycle", cyc, e.done_cyc);
        check("busy_with_done", 32'(busy), 32'd1);
      end
    end
  end

  // Issue one request from IDLE; returns #1 after the accept edge with start low.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        input logic [15:0] expv, input bit push);
    exp_t e;
    a     = av;
    b     = bv;
    start = 1'b1;
    if (push) begin
      e.prod     = expv;
      e.done_cyc = cyc + 1 + steps_for(bv);
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) check("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned busy_cnt;
    int unsigned done_cnt;
    int unsigned p;
    int unsigned k;
    exp_t e;
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", 32'(product), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 13 * 11 = 143; busy spans steps + DONE, done is one cycle wide.
    run_op(8'd13, 8'd11, 16'd143, 1'b1);
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cnt++;
      if (busy !== 1'b1) break;
      @(posedge clk); #1;
    end
    check("busy_cycles", busy_cnt, steps_for(8'd11) + 1);
    check("done_width", done_cnt, 32'd1);
    check("product_held", 32'(product), 32'd143);

    run_op(8'hFF, 8'hFF, 16'hFE01, 1'b1);
    wait_idle();
    run_op(8'hA5, 8'h00, 16'h0000, 1'b1);
    wait_idle();
    run_op(8'd1, 8'h80, 16'h0080, 1'b1);
    wait_idle();

    // In-flight start and operand change must be ignored.
    run_op(8'd7, 8'd6, 16'd42, 1'b1);
    wait_idle();
    run_op(8'd3, 8'd5, 16'd15, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("product_mid_run", 32'(product), 32'd42);
    start = 1'b1;
    a     = 8'd9;
    b     = 8'd9;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    check("product_after_inflight", 32'(product), 32'd15);

    // Reset at RUN step 5 discards the partial result.
    run_op(8'd200, 8'd100, 16'd0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrun_rst_busy", 32'(busy), 32'd0);
    check("midrun_rst_done", 32'(done), 32'd0);
    check("midrun_rst_product", 32'(product), 32'd0);
    repeat (10) begin
      @(posedge clk); #1;
      check("no_done_after_rst", 32'(done), 32'd0);
    end
    run_op(8'd200, 8'd100, 16'd20000, 1'b1);
    wait_idle();

    // start held high: one result every steps+2 cycles.
    p = steps_for(8'd4) + 2;
    k = cyc;
    a = 8'd3;
    b = 8'd4;
    start = 1'b1;
    for (int n = 0; n < 3; n++) begin
      e.prod     = 16'd12;
      e.done_cyc = k + 1 + n * p + steps_for(8'd4);
      sb_q.push_back(e);
    end
    repeat (3 * p) @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();

    // rst and start together: reset wins.
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    check("rst_start_busy", 32'(busy), 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    check("rst_start_idle", 32'(busy), 32'd0);
    check("rst_start_product", 32'(product), 32'd0);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
